byte_bus_arbiter: RTL and testbench
===================================

BYTE_BUS_ARBITER -- requirements
Module: byte_bus_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 m0_req, m1_req  in  1 each  transfer request from requester 0 (fetch) and requester 1 (data); level.
REQ-005 m0_we, m1_we  in  1 each  1 = write, 0 = read.
REQ-006 m0_addr, m1_addr  in  32 each  word address.
REQ-007 m0_wdata, m1_wdata  in  32 each  write data.
REQ-008 m0_done, m1_done  out  1 each  one-cycle completion pulse.
REQ-009 rdata  out  32  read data, valid in the cycle where either done is high.
REQ-010 busy  out  1  high from grant through the DONE cycle.
REQ-011 bus_out  out  8  address/command byte to pads.
REQ-012 bus_dout  out  8  write data byte to pads.
REQ-013 bus_din  in  8  read data byte from pads.
REQ-014 bus_oe  out  8  pad output enable; 8'hFF or 8'h00 only.
REQ-015 bus_phase  out  4  current byte slot, encoded as below.

Function
REQ-016 FSM states SHALL be IDLE (phase 0), ADDR (phases 1-4), CMD (phase 5), DATA (phases 6-9), DONE (phase 10).
- bus_phase is registered and equals the current state/slot.
REQ-017 In IDLE, if any req is high at a rising edge, the block SHALL latch the winner's we/addr/wdata and enter phase 1 on that edge.
- Later changes on the requester inputs have no effect on the transfer.
REQ-018 Arbitration SHALL be round-robin.
- A single requester wins.
- If both request, the one not granted last wins.
- The last-grant pointer resets to requester 1, so requester 0 wins the first tie.
REQ-019 Phases 1-4 SHALL drive bus_out = addr[7:0], [15:8], [23:16], [31:24] respectively.
REQ-020 Phase 5 SHALL drive bus_out = {7'b0, we}.
REQ-021 Phases 6-9 on write SHALL drive bus_dout = wdata bytes LSB first and bus_oe = 8'hFF.
- bus_oe is 8'h00 in every other phase and on reads.
REQ-022 Phases 6-9 on read SHALL sample bus_din at the rising edge ending each phase into rdata bytes 0-3 respectively.
REQ-023 Phase 10 SHALL pulse the granted requester's done for exactly one cycle.
- rdata holds the assembled word (read) or is unchanged (write).
- The state returns to IDLE on the next edge.
REQ-024 Latency from the grant edge to the done cycle SHALL be exactly 10 cycles.
- The minimum spacing between back-to-back grants is 11 cycles: DONE is always followed by one IDLE cycle.
REQ-025 A req deasserted mid-transfer SHALL NOT abort the transfer.
- The transfer completes and done still pulses.
REQ-026 A req still high during DONE SHALL be arbitrated as a new request in the following IDLE cycle.
REQ-027 Outside phases 1-5, bus_out SHALL be 8'h00.
- Outside write phases 6-9, bus_dout SHALL be 8'h00.
REQ-028 bus_phase SHALL only ever take the values 0-10.
- The phase counter never wraps past 10.

Reset
REQ-029 While rst_n is low, the block SHALL hold all outputs at 0 without waiting for clk: bus_out, bus_dout, bus_oe, bus_phase, rdata, busy, m0_done, m1_done.
- FSM is in IDLE.
- The round-robin pointer is at requester 1.
REQ-030 Reset asserted mid-transfer SHALL abort it with no done pulse.
- The first grant after release follows REQ-017/REQ-018.

Verification
REQ-031 Reset: rst_n low for 3 cycles with both reqs high -> all outputs 0 and phase 0 throughout; first grant after release goes to m0.
REQ-032 m0 write, addr 0x12345678, wdata 0xCAFEF00D -> expected response:
- bus_out 78,56,34,12 on phases 1-4, then 01 on phase 5.
- bus_dout 0D,F0,FE,CA with bus_oe FF on phases 6-9.
- m0_done high 10 cycles after grant.
REQ-033 m1 read, addr 0x00000010, bus_din 11,22,33,44 on phases 6-9 -> expected response:
- bus_out on phase 5 = 00.
- bus_oe 00 throughout.
- rdata = 0x44332211 with m1_done.
REQ-034 m0_req and m1_req held high continuously -> expected response:
- Grants alternate m0, m1, m0, m1.
- Done pulses are 11 cycles apart.
- One IDLE cycle separates transfers.
REQ-035 rst_n asserted asynchronously during phase 7 of a write -> expected response:
- Outputs go to 0 immediately.
- No done pulse occurs.
- Phase is 0 after release.
REQ-036 m1 read with m1_req dropped after the grant edge and m1_addr changed during phase 2 -> expected response:
- The transfer completes using the latched address.
- m1_done pulses once.

Source files
------------

// File: rtl/byte_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : byte_bus_arbiter
// Purpose  : Round-robin arbiter for two requesters sharing an 8-bit pad bus.
//            A grant serialises the transfer into fixed slots:
//            4 address bytes, 1 command byte, then 4 data bytes (LSB first),
//            followed by a one-cycle DONE slot.
// Revision : 1.0 - initial release
// ============================================================================
module byte_bus_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_done,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_done,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [7:0]  bus_out,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din,
    output logic [7:0]  bus_oe,
    output logic [3:0]  bus_phase
);

    // Slot encoding; the state value is also the externally visible phase.
    localparam logic [3:0] PH_IDLE  = 4'd0;
    localparam logic [3:0] PH_ADDR0 = 4'd1;
    localparam logic [3:0] PH_ADDR1 = 4'd2;
    localparam logic [3:0] PH_ADDR2 = 4'd3;
    localparam logic [3:0] PH_ADDR3 = 4'd4;
    localparam logic [3:0] PH_CMD   = 4'd5;
    localparam logic [3:0] PH_DATA0 = 4'd6;
    localparam logic [3:0] PH_DATA3 = 4'd9;
    localparam logic [3:0] PH_DONE  = 4'd10;

    logic [3:0]  phase_q, phase_d;
    logic        gnt_q, gnt_d;       // owner of the current transfer (1 = requester 1)
    logic        last_q, last_d;     // requester granted most recently
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        winner_w;
    logic        in_data_w;
    logic [1:0]  dbyte_w;

    // On a tie the requester not served last wins; otherwise whoever asks.
    assign winner_w  = (m0_req && m1_req) ? ~last_q : m1_req;
    assign in_data_w = (phase_q >= PH_DATA0) && (phase_q <= PH_DATA3);
    // Phases 6..9 map to byte lanes 0..3 via the low two phase bits.
    assign dbyte_w   = phase_q[1:0] + 2'd2;

    // State register plus the transfer context latched at grant time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            phase_q <= phase_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state: grant from IDLE, advance one slot per cycle, back to IDLE after DONE
    always_comb begin
        phase_d = phase_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (phase_q)
            PH_IDLE: begin
                if (m0_req || m1_req) begin
                    phase_d = PH_ADDR0;
                    gnt_d   = winner_w;
                    last_d  = winner_w;
                    we_d    = winner_w ? m1_we    : m0_we;
                    addr_d  = winner_w ? m1_addr  : m0_addr;
                    wdata_d = winner_w ? m1_wdata : m0_wdata;
                end
            end
            PH_DONE: phase_d = PH_IDLE;
            // Any out-of-range encoding falls back to IDLE rather than counting on.
            default: phase_d = (phase_q < PH_DONE) ? phase_q + 4'd1 : PH_IDLE;
        endcase
        // Reads capture one pad byte at the edge closing each data slot.
        if (in_data_w && !we_q) begin
            rdata_d[{dbyte_w, 3'b000} +: 8] = bus_din;
        end
    end

    // Pad drive decoded from the current slot; everything idles at zero
    always_comb begin
        bus_out  = 8'h00;
        bus_dout = 8'h00;
        bus_oe   = 8'h00;
        case (phase_q)
            PH_ADDR0: bus_out = addr_q[7:0];
            PH_ADDR1: bus_out = addr_q[15:8];
            PH_ADDR2: bus_out = addr_q[23:16];
            PH_ADDR3: bus_out = addr_q[31:24];
            PH_CMD:   bus_out = {7'b0, we_q};
            default:  ;
        endcase
        if (in_data_w && we_q) begin
            bus_oe   = 8'hFF;
            bus_dout = wdata_q[{dbyte_w, 3'b000} +: 8];
        end
    end

    assign bus_phase = phase_q;
    assign busy      = (phase_q != PH_IDLE);
    assign m0_done   = (phase_q == PH_DONE) && !gnt_q;
    assign m1_done   = (phase_q == PH_DONE) &&  gnt_q;
    assign rdata     = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_bus_arbiter
// Purpose  : Self-checking bench for byte_bus_arbiter: table of transfers
//            plus hand-written reset/alternation/input-change sequences,
//            all checked through an expected-value scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_byte_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_done, m1_done, busy;
    logic [31:0] rdata;
    logic [7:0]  bus_out, bus_dout, bus_din, bus_oe;
    logic [3:0]  bus_phase;

    byte_bus_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_done  (m0_done),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_done  (m1_done),
        .rdata    (rdata),
        .busy     (busy),
        .bus_out  (bus_out),
        .bus_dout (bus_dout),
        .bus_din  (bus_din),
        .bus_oe   (bus_oe),
        .bus_phase(bus_phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ph;
        logic [7:0]  bout;
        logic [7:0]  bdout;
        logic [7:0]  boe;
        logic        busy;
        logic        d0;
        logic        d1;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        logic        req0;
        logic        req1;
        logic        exp_m1;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] din;
    } vec_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          done_cyc[$];
    logic [31:0] model_rd;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected pad/status values for one slot of a transfer.
    function automatic exp_t mk_exp(input int ph, input logic m1, input logic we,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] rd, input logic chk_rd);
        exp_t e;
        e.ph     = 4'(ph);
        e.bout   = 8'h00;
        e.bdout  = 8'h00;
        e.boe    = 8'h00;
        e.busy   = (ph != 0);
        e.d0     = (ph == 10) && !m1;
        e.d1     = (ph == 10) && m1;
        e.chk_rd = chk_rd;
        e.rd     = rd;
        if (ph >= 1 && ph <= 4) e.bout = addr[8*(ph-1) +: 8];
        if (ph == 5)            e.bout = {7'b0, we};
        if (ph >= 6 && ph <= 9 && we) begin
            e.boe   = 8'hFF;
            e.bdout = wdata[8*(ph-6) +: 8];
        end
        return e;
    endfunction

    task automatic check_pop(input string name);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty at cycle %0d", name, cyc);
            return;
        end
        e = sb.pop_front();
        if (bus_phase !== e.ph || bus_out !== e.bout || bus_dout !== e.bdout ||
            bus_oe !== e.boe || busy !== e.busy || m0_done !== e.d0 ||
            m1_done !== e.d1 || (e.chk_rd && rdata !== e.rd)) begin
            n_fail++;
            $display("FAIL %s cyc %0d: got ph=%0d out=%h dout=%h oe=%h busy=%b d0=%b d1=%b rdata=%h; required ph=%0d out=%h dout=%h oe=%h busy=%b d0=%b d1=%b rdata=%h(chk=%b)",
                     name, cyc, bus_phase, bus_out, bus_dout, bus_oe, busy, m0_done, m1_done, rdata,
                     e.ph, e.bout, e.bdout, e.boe, e.busy, e.d0, e.d1, e.rd, e.chk_rd);
        end
    endtask

    // All outputs must be at their reset/idle value right now.
    task automatic expect_idle(input string name, input logic [31:0] rd);
        sb.push_back(mk_exp(0, 1'b0, 1'b0, 32'h0, 32'h0, rd, 1'b1));
        check_pop(name);
    endtask

    // Winner sees the real fields; the loser sees inverted ones so a wrong grant shows up.
    task automatic drive(input logic r0, input logic r1, input logic m1, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        m0_req   = r0;
        m1_req   = r1;
        m0_we    = m1 ? ~we    : we;
        m0_addr  = m1 ? ~addr  : addr;
        m0_wdata = m1 ? ~wdata : wdata;
        m1_we    = m1 ? we     : ~we;
        m1_addr  = m1 ? addr   : ~addr;
        m1_wdata = m1 ? wdata  : ~wdata;
    endtask

    // One full transfer from the grant edge through the trailing IDLE slot.
    task automatic do_xfer(input string name, input logic m1, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] din, input bit hold, input bit scramble);
        logic [31:0] rd_after;
        rd_after = we ? model_rd : din;
        for (int p = 1; p <= 10; p++)
            sb.push_back(mk_exp(p, m1, we, addr, wdata, rd_after, p == 10));
        sb.push_back(mk_exp(0, m1, we, addr, wdata, rd_after, 1'b1));
        model_rd = rd_after;
        for (int k = 1; k <= 11; k++) begin
            step();
            check_pop(name);
            if (m0_done === 1'b1 || m1_done === 1'b1) done_cyc.push_back(cyc);
            if (!hold && k == 1) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            if (scramble && k == 2) begin
                m0_addr  = ~m0_addr;  m1_addr  = ~m1_addr;
                m0_wdata = ~m0_wdata; m1_wdata = ~m1_wdata;
                m0_we    = ~m0_we;    m1_we    = ~m1_we;
            end
            bus_din = (k >= 6 && k <= 9) ? din[8*(k-6) +: 8] : 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h12345678, 32'hCAFEF00D, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00000010, 32'h0,        32'h44332211};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A50001, 32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000FFFF, 32'h01020304, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h0,        32'h80000001};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00000007, 32'h0,        32'h5A5AC3C3};

        // Reset held with both requesters asking: everything stays at zero.
        rst_n   = 1'b0;
        bus_din = 8'h00;
        drive(1'b1, 1'b1, 1'b0, vecs[0].we, vecs[0].addr, vecs[0].wdata);
        model_rd = 32'h0;
        #1;
        expect_idle("reset_async", 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_idle("reset_hold", 32'h0);
        end
        rst_n = 1'b1;

        // Table of single transfers; first entry is the post-reset tie (m0 must win).
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].req0, vecs[i].req1, vecs[i].exp_m1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            do_xfer($sformatf("vec%0d", i), vecs[i].exp_m1, vecs[i].we,
                    vecs[i].addr, vecs[i].wdata, vecs[i].din, 1'b0, 1'b0);
        end

        // Both requests held: grants alternate m0/m1 with 11-cycle done spacing.
        done_cyc.delete();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h00000100; m0_wdata = 32'h89ABCDEF;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h00000200; m1_wdata = 32'h0;
        do_xfer("alt_m0a", 1'b0, 1'b1, 32'h00000100, 32'h89ABCDEF, 32'h0,        1'b1, 1'b0);
        do_xfer("alt_m1a", 1'b1, 1'b0, 32'h00000200, 32'h0,        32'h0BADF00D, 1'b1, 1'b0);
        do_xfer("alt_m0b", 1'b0, 1'b1, 32'h00000100, 32'h89ABCDEF, 32'h0,        1'b1, 1'b0);
        m0_req = 1'b0;
        m1_req = 1'b1;
        do_xfer("alt_m1b", 1'b1, 1'b0, 32'h00000200, 32'h0,        32'h600DCAFE, 1'b1, 1'b0);
        m1_req = 1'b0;
        n_checks++;
        if (done_cyc.size() != 4) begin
            n_fail++;
            $display("FAIL alt_done_count: got %0d pulses, required 4", done_cyc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (done_cyc[i] - done_cyc[i-1] != 11) begin
                    n_fail++;
                    $display("FAIL alt_done_spacing%0d: got %0d cycles, required 11",
                             i, done_cyc[i] - done_cyc[i-1]);
                end
            end
        end

        // m1 read: request dropped after grant, inputs changed during phase 2.
        done_cyc.delete();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h13572468, 32'h0);
        do_xfer("latched_read", 1'b1, 1'b0, 32'h13572468, 32'h0, 32'hFEDCBA98, 1'b0, 1'b1);
        n_checks++;
        if (done_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL latched_done_once: got %0d pulses, required 1", done_cyc.size());
        end

        // Asynchronous reset during phase 7 of a write aborts it silently.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0BADBEEF, 32'h11223344);
        for (int p = 1; p <= 7; p++)
            sb.push_back(mk_exp(p, 1'b0, 1'b1, 32'h0BADBEEF, 32'h11223344, model_rd, 1'b0));
        for (int p = 1; p <= 7; p++) begin
            step();
            check_pop("abort_pre");
            if (p == 1) m0_req = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_rd = 32'h0;
        expect_idle("abort_immediate", 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            expect_idle("abort_hold", 32'h0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_idle("abort_after", 32'h0);
        end

        // Pointer is back at requester 1, so the first tie goes to m0.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hC0FFEE00, 32'h0);
        do_xfer("post_reset_tie", 1'b0, 1'b0, 32'hC0FFEE00, 32'h0, 32'h76543210, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
